// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by fetch, the fetch queue and decode.
//   NOP_INSTR  : instruction decode sees when nothing valid is presented
//   IMEM_BASE  : reset PC / base of instruction memory
//   fq_entry_t : one queued instruction/PC pair
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h7800_0000;
  localparam logic [31:0] IMEM_BASE = 32'h0600_2000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Register array backing the fetch queue.
// Ports:
//   clk      : system clock
//   wr_en    : write wr_data into entry wr_addr on the rising edge
//   wr_addr  : write index
//   wr_data  : entry to store
//   rd_addr  : read index
//   rd_data  : entry at rd_addr (combinational read)
// The array is intentionally not reset; validity is tracked by the queue.
module fetch_queue_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  fq_entry_t        wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output fq_entry_t        rd_data
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_instr   : instruction from fetch
//   in_pc      : PC of in_instr
//   in_valid   : fetch Done; pair is valid this cycle
//   stall      : decode cannot accept an entry this cycle
//   flush      : branch taken; discard queued and incoming entries
//   out_instr  : head instruction, NOP_INSTR when out_valid=0
//   out_pc     : head PC, 0 when out_valid=0
//   out_valid  : a queued entry is presented
//   full       : count == DEPTH; fetch must hold its PC
//   count      : occupied entries
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             out_valid,
  output logic             full,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  fq_entry_t        wr_data;
  fq_entry_t        head;

  assign out_valid = (count != '0);
  assign full      = (count == DEPTH_C);

  // full comes only from registered count, so a push is refused when full
  // even if the head is popped in the same cycle.
  assign push = in_valid && !full && !flush;
  assign pop  = out_valid && !stall && !flush;

  assign wr_data = '{instr: in_instr, pc: in_pc};

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    out_instr = NOP_INSTR;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = head.instr;
      out_pc    = head.pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic             out_valid;
  logic             full;
  logic [PTR_W:0]   count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fq_entry_t model_q[$];

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_valid  (in_valid),
    .stall     (stall),
    .flush     (flush),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_valid (out_valid),
    .full      (full),
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs against what the model's current contents imply.
  task automatic check_outputs(input string tag);
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    e_instr = NOP_INSTR;
    e_pc    = 32'h0;
    if (model_q.size() != 0) begin
      e_instr = model_q[0].instr;
      e_pc    = model_q[0].pc;
    end
    check({tag, ".count"}, 64'(count), 64'(model_q.size()));
    check({tag, ".valid"}, 64'(out_valid), 64'(model_q.size() != 0));
    check({tag, ".full"},  64'(full), 64'(model_q.size() == DEPTH));
    check({tag, ".instr"}, 64'(out_instr), 64'(e_instr));
    check({tag, ".pc"},    64'(out_pc), 64'(e_pc));
  endtask

  // One clock cycle: drive, check mid-cycle, clock edge, update model.
  task automatic step(input string tag, input logic [31:0] i, input logic [31:0] p,
                      input logic v, input logic s, input logic f);
    int unsigned sz;
    in_instr = i;
    in_pc    = p;
    in_valid = v;
    stall    = s;
    flush    = f;
    #4;
    check_outputs(tag);
    @(posedge clk);
    sz = model_q.size();
    if (f) begin
      model_q.delete();
    end else begin
      if (sz != 0 && !s) void'(model_q.pop_front());
      if (v && sz < DEPTH) model_q.push_back('{instr: i, pc: p});
    end
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    rst      = 1'b1;
    in_instr = '0;
    in_pc    = '0;
    in_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    #12;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Three pushes, drained with no stall, then NOP.
    for (int k = 0; k < 3; k++)
      step("basic", $urandom, IMEM_BASE + 32'(4 * k), 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      step("basic_drain", '0, '0, 1'b0, 1'b0, 1'b0);

    // Stalled fill past DEPTH; fifth entry is refused.
    for (int k = 0; k < 5; k++)
      step("fill", $urandom, IMEM_BASE + 32'h100 + 32'(4 * k), 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++)
      step("drain", '0, '0, 1'b0, 1'b0, 1'b0);

    // Flush with count=2 and a concurrent in_valid.
    step("pre_flush", $urandom, IMEM_BASE + 32'h200, 1'b1, 1'b1, 1'b0);
    step("pre_flush", $urandom, IMEM_BASE + 32'h204, 1'b1, 1'b1, 1'b0);
    step("flush", $urandom, IMEM_BASE + 32'h208, 1'b1, 1'b0, 1'b1);
    step("post_flush", $urandom, IMEM_BASE + 32'h300, 1'b1, 1'b0, 1'b0);
    step("post_flush", '0, '0, 1'b0, 1'b0, 1'b0);

    // Streaming push+pop across the pointer wrap.
    step("stream_prime", $urandom, IMEM_BASE, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++)
      step("stream", $urandom, IMEM_BASE + 32'(4 * k), 1'b1, 1'b0, 1'b0);
    step("stream_end", '0, '0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream with count=3.
    for (int k = 0; k < 3; k++)
      step("pre_rst", $urandom, IMEM_BASE + 32'h400 + 32'(4 * k), 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    model_q.delete();
    #1;
    check_outputs("async_rst");
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step("after_rst", $urandom, IMEM_BASE, 1'b1, 1'b0, 1'b0);
    step("after_rst", '0, '0, 1'b0, 1'b0, 1'b0);
    step("after_rst", '0, '0, 1'b0, 1'b0, 1'b0);

    // Pop and push together while full: pop only.
    for (int k = 0; k < DEPTH; k++)
      step("full_fill", $urandom, IMEM_BASE + 32'h500 + 32'(4 * k), 1'b1, 1'b1, 1'b0);
    step("full_popush", $urandom, IMEM_BASE + 32'h600, 1'b1, 1'b0, 1'b0);
    step("full_after", '0, '0, 1'b0, 1'b1, 1'b0);

    // Random traffic; fetch honours full, so never pushes while full.
    pc = IMEM_BASE;
    for (int k = 0; k < 400; k++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0) && (model_q.size() < DEPTH);
      step("rand", $urandom, pc, v, $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
      pc = pc + 32'd4;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
